// File: rtl/l1_arb_pkg.sv
// Shared types and default widths for the L1 I/D miss-port to L2 arbiter.
package l1_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/l1_l2_arbiter_if.sv
// Bus bundle between the split L1 miss ports, the arbiter and the L2 request port.
interface l1_l2_arbiter_if
  import l1_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
);

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  // Arbiter side
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address, l2_wdata
  );

  // Caches / L2 side
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address, l2_wdata
  );

endinterface

// File: rtl/l1_arb_latch.sv
// Load-enabled holding register for the granted address, write data and operation.
module l1_arb_latch
  import l1_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [LINE_W-1:0] wdata_in,
  input  arb_op_t           op_in,
  output logic [ADDR_W-1:0] addr,
  output logic [LINE_W-1:0] wdata,
  output arb_op_t           op
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr  <= '0;
      wdata <= '0;
      op    <= OP_READ;
    end else if (load) begin
      addr  <= addr_in;
      wdata <= wdata_in;
      op    <= op_in;
    end
  end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Grants the I or D miss port onto the single L2 port and returns the response.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin instead of D-first priority.
module l1_l2_arbiter
  import l1_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  l1_l2_arbiter_if.slave  bus
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              i_req;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;
  logic              load;
  logic [ADDR_W-1:0] addr_in;
  logic [LINE_W-1:0] wdata_in;
  arb_op_t           op_in;
  logic [ADDR_W-1:0] addr_lat;
  logic [LINE_W-1:0] wdata_lat;
  arb_op_t           op_lat;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;  // 0: I served last, 1: D served last

  assign grant_d = d_req & (~i_req | ~last_grant);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_grant <= 1'b0;
    else if (load)
      last_grant <= grant_d;
  end
`else
  assign grant_d = d_req;
`endif

  assign grant_i = i_req & ~grant_d;
  assign load    = (state == IDLE) & (grant_i | grant_d);

  // A simultaneous d_read/d_write is treated as a writeback.
  always_comb begin
    addr_in  = grant_d ? bus.d_address : bus.i_address;
    wdata_in = grant_d ? bus.d_wdata : '0;
    op_in    = (grant_d & bus.d_write) ? OP_WRITE : OP_READ;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = SERVE_D;
        else if (grant_i) state_nxt = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (bus.l2_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  l1_arb_latch #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_latch (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .addr_in  (addr_in),
    .wdata_in (wdata_in),
    .op_in    (op_in),
    .addr     (addr_lat),
    .wdata    (wdata_lat),
    .op       (op_lat)
  );

  // Strobes come straight from flops; responses are combinational on l2_resp.
  assign bus.l2_read    = (state != IDLE) & (op_lat == OP_READ);
  assign bus.l2_write   = (state != IDLE) & (op_lat == OP_WRITE);
  assign bus.l2_address = addr_lat;
  assign bus.l2_wdata   = wdata_lat;

  assign bus.i_resp  = (state == SERVE_I) & bus.l2_resp;
  assign bus.d_resp  = (state == SERVE_D) & bus.l2_resp;
  assign bus.i_rdata = bus.l2_rdata;
  assign bus.d_rdata = bus.l2_rdata;

endmodule
